// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default geometry for the block-memory access controller.
package mem_access_ctrl_pkg;

  localparam int              ADDR_W_DEF     = 10;
  localparam int              DATA_W_DEF     = 16;
  localparam int              REQ_ADDR_W_DEF = 16;
  localparam logic [15:0]     MMIO_ADDR_DEF  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_addr_decode.sv
// Address decode: splits a processor word address into memory range, I/O hit and word index.
// Purely combinational, no backpressure.
module mem_addr_decode
  import mem_access_ctrl_pkg::*;
#(
  parameter int                    ADDR_W     = ADDR_W_DEF,
  parameter int                    REQ_ADDR_W = REQ_ADDR_W_DEF,
  parameter logic [REQ_ADDR_W-1:0] MMIO_ADDR  = MMIO_ADDR_DEF
) (
  input  logic [REQ_ADDR_W-1:0] req_addr,
  output logic                  in_range,
  output logic                  is_mmio,
  output logic [ADDR_W-1:0]     word_addr
);

  assign in_range  = (req_addr[REQ_ADDR_W-1:ADDR_W] == '0);
  assign is_mmio   = (req_addr == MMIO_ADDR);
  assign word_addr = req_addr[ADDR_W-1:0];

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a 1-cycle registered single-port RAM; optional I/O register with MEM_MMIO_EN.
// Response 3 cycles after accept (1 for error/I/O); one request in flight, req_ready low until back in IDLE.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int                    ADDR_W     = ADDR_W_DEF,
  parameter int                    DATA_W     = DATA_W_DEF,
  parameter int                    REQ_ADDR_W = REQ_ADDR_W_DEF,
  parameter logic [REQ_ADDR_W-1:0] MMIO_ADDR  = MMIO_ADDR_DEF
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wea,
  output logic [ADDR_W-1:0]     mem_addra,
  output logic [DATA_W-1:0]     mem_dina,
  input  logic [DATA_W-1:0]     mem_douta
`ifdef MEM_MMIO_EN
  ,
  input  logic [DATA_W-1:0]     io_in,
  output logic [DATA_W-1:0]     io_out
`endif
);

`ifdef MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
  logic [DATA_W-1:0] mmio_rd;
  assign mmio_rd = io_in;
`else
  localparam bit MMIO_EN = 1'b0;
  logic [DATA_W-1:0] mmio_rd;
  assign mmio_rd = '0;
`endif

  state_t            state, state_nxt;
  logic              in_range, is_mmio, mmio_hit;
  logic [ADDR_W-1:0] word_addr;

  mem_addr_decode #(
    .ADDR_W     (ADDR_W),
    .REQ_ADDR_W (REQ_ADDR_W),
    .MMIO_ADDR  (MMIO_ADDR)
  ) u_decode (
    .req_addr  (req_addr),
    .in_range  (in_range),
    .is_mmio   (is_mmio),
    .word_addr (word_addr)
  );

  assign mmio_hit = MMIO_EN && is_mmio;

  always_ff @(posedge clka) begin
    if (rsta) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (in_range && !mmio_hit) ? ACCESS : RESP;
      end
      ACCESS:  state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rsp_valid is registered off RESP so rdata/err are already stable when it rises.
  always_ff @(posedge clka) begin
    if (rsta) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_wea   <= 1'b0;
      mem_addra <= '0;
      mem_dina  <= '0;
    end else begin
      rsp_valid <= (state == RESP);
      mem_wea   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (mmio_hit) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= req_we ? req_wdata : mmio_rd;
          end else if (in_range) begin
            mem_addra <= word_addr;
            mem_dina  <= req_wdata;
            mem_wea   <= req_we;
          end else begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        WAIT: begin
          rsp_rdata <= mem_douta;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MMIO_EN
  always_ff @(posedge clka) begin
    if (rsta)                                        io_out <= '0;
    else if (state == IDLE && req_valid && mmio_hit && req_we) io_out <= req_wdata;
  end
`endif

endmodule
